// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the Dino game sprite layer.
//   rgb565_t      16-bit RGB565 pixel
//   SPR_W/SPR_H   default sprite size in pixels
//   REG_*         Avalon-MM word addresses of the non-position registers
//   RST_*         reset values of positions and background colour
//   pos_reg_addr  word address of a sprite's x (is_y=0) or y (is_y=1) register
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int SPR_W = 32;
    localparam int SPR_H = 32;

    localparam logic [8:0] REG_EN     = 9'h10;
    localparam logic [8:0] REG_COMMIT = 9'h11;
    localparam logic [8:0] REG_BG     = 9'h12;

    localparam logic [9:0] RST_POS = 10'h3FF;
    localparam rgb565_t    RST_BG  = 16'hFFFF;

    function automatic logic [8:0] pos_reg_addr(input int idx, input logic is_y);
        return 9'(2 * idx) | {8'b0, is_y};
    endfunction

endpackage

// File: rtl/sprite_layer_ctrl_if.sv
// -----------------------------------------------------------------------------
// sprite_layer_ctrl_if
// Avalon-MM write-only slave bus of the sprite layer register file.
//   chipselect  slave select
//   write       single-cycle write strobe, no wait states
//   address     9-bit word address
//   writedata   32-bit write data
// Handshake: a write is accepted on every rising clock edge where
// chipselect && write is high; there is no waitrequest, so the slave is
// always ready and the master never holds a transfer longer than one cycle.
// Modports: master drives the bus, slave (sprite_layer_ctrl) receives it.
// -----------------------------------------------------------------------------
interface sprite_layer_ctrl_if;

    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, output write, output address, output writedata);
    modport slave  (input  chipselect, input  write, input  address, input  writedata);

endinterface

// File: rtl/sprite_hit_unit.sv
// -----------------------------------------------------------------------------
// sprite_hit_unit
// First pipeline stage for one sprite: tests whether the current pixel falls
// inside the sprite's box and registers the sprite ROM address.
//   clk, reset   clock, synchronous active-high reset
//   en           live enable of this sprite
//   blank_n      high in the active display area
//   px, py       current pixel coordinates
//   x, y         live top-left corner of the sprite
//   hit          registered: pixel is inside the enabled sprite
//   addr         registered ROM address, 0 when there is no hit
// -----------------------------------------------------------------------------
module sprite_hit_unit #(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              blank_n,
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    // 11-bit compares: x + SPR_W never wraps, so sprites near the right or
    // bottom edge clip instead of reappearing at the left or top.
    logic [10:0] px_w, py_w, x_w, y_w;
    logic [10:0] dx, dy;
    logic        hit_c;
    logic [31:0] lin;

    always_comb begin
        px_w  = {1'b0, px};
        py_w  = {1'b0, py};
        x_w   = {1'b0, x};
        y_w   = {1'b0, y};
        dx    = px_w - x_w;
        dy    = py_w - y_w;
        hit_c = en && blank_n
                && (px_w >= x_w) && (px_w < x_w + 11'(SPR_W))
                && (py_w >= y_w) && (py_w < y_w + 11'(SPR_H));
        lin   = 32'(dy) * 32'(SPR_W) + 32'(dx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit  <= 1'b0;
            addr <= '0;
        end else begin
            hit  <= hit_c;
            addr <= hit_c ? lin[ADDR_W-1:0] : '0;
        end
    end

endmodule

// File: rtl/sprite_layer_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_layer_ctrl
// Sprite layer of the Dino game: Avalon-MM register file with shadow/live
// position, enable and background registers, per-sprite ROM addressing and a
// priority resolver producing one RGB565 pixel for the VGA output stage.
// Ports:
//   clk, reset    50 MHz clock, synchronous active-high reset
//   bus           Avalon-MM slave (chipselect, write, address, writedata)
//   frame_start   1-cycle pulse at the start of vertical blank
//   hcount        pixel x = hcount[10:1]
//   vcount        pixel y
//   blank_n       high in the active display area
//   spr_addr      per-sprite ROM address, registered (ADDR_W bits each)
//   spr_data      per-sprite ROM data, 1-cycle read latency (16 bits each)
//   pix_rgb       output pixel
//   pix_hit       an opaque sprite is selected
//   pix_sel       index of the winning sprite, 0 with no hit
//   commit_pend   commit requested but not yet applied
// Pixel latency from hcount/vcount to pix_* is 3 clocks.
// Build option: define SPRITE_COLORKEY_EN to make sprite pixels equal to
// COLORKEY transparent; otherwise every hit pixel is opaque.
// -----------------------------------------------------------------------------
module sprite_layer_ctrl #(
    parameter int          NUM_SPRITES = 6,
    parameter int          SPR_W       = sprite_pkg::SPR_W,
    parameter int          SPR_H       = sprite_pkg::SPR_H,
    parameter int          ADDR_W      = 10,
    parameter logic [15:0] COLORKEY    = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    sprite_layer_ctrl_if.slave            bus,
    input  logic                          frame_start,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          blank_n,
    output logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
    input  logic [NUM_SPRITES*16-1:0]     spr_data,
    output logic [15:0]                   pix_rgb,
    output logic                          pix_hit,
    output logic [2:0]                    pix_sel,
    output logic                          commit_pend
);

    import sprite_pkg::*;

`ifdef SPRITE_COLORKEY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    logic [9:0]             shadow_x [NUM_SPRITES];
    logic [9:0]             shadow_y [NUM_SPRITES];
    logic [9:0]             live_x   [NUM_SPRITES];
    logic [9:0]             live_y   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] shadow_en;
    logic [NUM_SPRITES-1:0] live_en;
    rgb565_t                bg;

    logic wr;
    assign wr = bus.chipselect && bus.write;

    // hcount[0] is the sub-pixel bit and the upper write data bits are not
    // mapped to any register.
    logic unused_bits;
    assign unused_bits = ^{hcount[0], bus.writedata[31:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x[i] <= RST_POS;
                shadow_y[i] <= RST_POS;
                live_x[i]   <= RST_POS;
                live_y[i]   <= RST_POS;
            end
            shadow_en   <= '0;
            live_en     <= '0;
            bg          <= RST_BG;
            commit_pend <= 1'b0;
        end else begin
            // Live takes the shadow value from before this edge, so a write
            // landing in the commit cycle waits for the next frame.
            if (frame_start && commit_pend) begin
                live_x  <= shadow_x;
                live_y  <= shadow_y;
                live_en <= shadow_en;
            end

            if (wr) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (bus.address == pos_reg_addr(i, 1'b0)) shadow_x[i] <= bus.writedata[9:0];
                    if (bus.address == pos_reg_addr(i, 1'b1)) shadow_y[i] <= bus.writedata[9:0];
                end
                if (bus.address == REG_EN) shadow_en <= bus.writedata[NUM_SPRITES-1:0];
                if (bus.address == REG_BG) bg        <= bus.writedata[15:0];
            end

            // A commit request in the frame_start cycle survives the clear.
            if (wr && bus.address == REG_COMMIT && bus.writedata[0]) begin
                commit_pend <= 1'b1;
            end else if (frame_start) begin
                commit_pend <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // S0: per-sprite hit test and ROM address
    // ---------------------------------------------------------------------
    logic [NUM_SPRITES-1:0] hit_s0;
    logic [NUM_SPRITES-1:0] hit_s1;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .clk     (clk),
            .reset   (reset),
            .en      (live_en[g]),
            .blank_n (blank_n),
            .px      (hcount[10:1]),
            .py      (vcount),
            .x       (live_x[g]),
            .y       (live_y[g]),
            .hit     (hit_s0[g]),
            .addr    (spr_addr[g*ADDR_W +: ADDR_W])
        );
    end

    // ---------------------------------------------------------------------
    // S1: delay the hit vector to line up with the ROM read data
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) hit_s1 <= '0;
        else       hit_s1 <= hit_s0;
    end

    // ---------------------------------------------------------------------
    // S2: priority select, lowest index wins
    // ---------------------------------------------------------------------
    logic [2:0] win_sel;
    logic       win_hit;
    rgb565_t    win_rgb;

    always_comb begin
        win_sel = '0;
        win_hit = 1'b0;
        win_rgb = bg;
        // Walk from the lowest priority upward so the last match is the winner.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1[i] && !(KEY_EN && spr_data[i*16 +: 16] == COLORKEY)) begin
                win_sel = 3'(i);
                win_hit = 1'b1;
                win_rgb = spr_data[i*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_rgb <= RST_BG;
            pix_hit <= 1'b0;
            pix_sel <= '0;
        end else begin
            pix_rgb <= win_rgb;
            pix_hit <= win_hit;
            pix_sel <= win_sel;
        end
    end

endmodule

// File: tb/tb_sprite_layer_ctrl.sv
module tb_sprite_layer_ctrl;

    localparam int NUM = 6;

`ifdef SPRITE_COLORKEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    sprite_layer_ctrl_if bus();

    logic              frame_start = 1'b0;
    logic [10:0]       hcount = '0;
    logic [9:0]        vcount = '0;
    logic              blank_n = 1'b0;
    logic [NUM*10-1:0] spr_addr;
    logic [NUM*16-1:0] spr_data = '0;
    logic [15:0]       pix_rgb;
    logic              pix_hit;
    logic [2:0]        pix_sel;
    logic              commit_pend;

    sprite_layer_ctrl #(.NUM_SPRITES(NUM)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .frame_start (frame_start),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n     (blank_n),
        .spr_addr    (spr_addr),
        .spr_data    (spr_data),
        .pix_rgb     (pix_rgb),
        .pix_hit     (pix_hit),
        .pix_sel     (pix_sel),
        .commit_pend (commit_pend)
    );

    // ---------------- sprite ROMs (1-cycle latency) ----------------
    bit key_mode = 1'b0;   // ROM 0 returns FFFF everywhere

    function automatic logic [15:0] rom_fn(input int i, input logic [9:0] a);
        if (key_mode && i == 0) return 16'hFFFF;
        return {3'(i), 3'b101, a};
    endfunction

    always @(posedge clk)
        for (int i = 0; i < NUM; i++)
            spr_data[i*16 +: 16] <= rom_fn(i, spr_addr[i*10 +: 10]);

    // ---------------- reference model ----------------
    int          m_sx[NUM], m_sy[NUM], m_lx[NUM], m_ly[NUM];
    logic [5:0]  m_sen, m_len;
    logic [15:0] m_bg;
    bit          m_pend;

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_sx[i] = 1023; m_sy[i] = 1023; m_lx[i] = 1023; m_ly[i] = 1023;
        end
        m_sen = '0; m_len = '0; m_bg = 16'hFFFF; m_pend = 1'b0;
    endtask

    function automatic logic [19:0] model_pixel(input int px, input int py, input bit blank);
        for (int i = 0; i < NUM; i++) begin
            if (blank && m_len[i] && px >= m_lx[i] && px < m_lx[i] + 32
                && py >= m_ly[i] && py < m_ly[i] + 32) begin
                logic [15:0] d;
                d = rom_fn(i, 10'((py - m_ly[i]) * 32 + (px - m_lx[i])));
                if (!(KEY_EN && d == 16'hFFFF)) return {d, 1'b1, 3'(i)};
            end
        end
        return {m_bg, 1'b0, 3'b0};
    endfunction

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic issue = 1'b0;
    logic [2:0] vpipe = '0;

    always @(posedge clk)
        if (reset) vpipe <= '0;
        else       vpipe <= {vpipe[1:0], issue};

    always @(negedge clk) begin
        if (vpipe[2]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_underflow: output presented with empty expected queue");
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({pix_rgb, pix_hit, pix_sel} !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got rgb=%h hit=%0d sel=%0d, expected rgb=%h hit=%0d sel=%0d",
                             pix_rgb, pix_hit, pix_sel, e[19:4], e[3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input int px, input int py, input bit blank, input bit fs,
                        input bit cs, input bit we, input logic [8:0] a,
                        input logic [31:0] d, input bit chk);
        bit new_pend;
        hcount = {10'(px), 1'($urandom_range(0, 1))};
        vcount = 10'(py);
        blank_n = blank;
        frame_start = fs;
        bus.chipselect = cs;
        bus.write = we;
        bus.address = a;
        bus.writedata = d;
        issue = chk;
        if (chk) exp_q.push_back(model_pixel(px, py, blank));
        // model update for this edge
        if (fs && m_pend) begin
            m_lx = m_sx; m_ly = m_sy; m_len = m_sen;
        end
        new_pend = fs ? 1'b0 : m_pend;
        if (cs && we) begin
            if (a < 9'(2 * NUM)) begin
                if (a[0]) m_sy[a >> 1] = int'(d[9:0]);
                else      m_sx[a >> 1] = int'(d[9:0]);
            end
            if (a == 9'h10) m_sen = d[5:0];
            if (a == 9'h12) m_bg = d[15:0];
            if (a == 9'h11 && d[0]) new_pend = 1'b1;
        end
        m_pend = new_pend;
        @(posedge clk); #1;
        frame_start = 1'b0;
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
        issue = 1'b0;
        check("commit_pend", {31'b0, commit_pend}, {31'b0, m_pend});
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        step(0, 0, 0, 0, 1, 1, a, d, 0);
    endtask

    task automatic pix(input int px, input int py);
        step(px, py, 1, 0, 0, 0, 9'h0, 32'h0, 1);
    endtask

    task automatic frame();
        step(0, 0, 0, 1, 0, 0, 9'h0, 32'h0, 0);
    endtask

    task automatic drain();
        repeat (4) step(0, 0, 0, 0, 0, 0, 9'h0, 32'h0, 0);
    endtask

    task automatic place(input int i, input int x, input int y);
        wr(9'(2 * i), 32'(x));
        wr(9'(2 * i + 1), 32'(y));
    endtask

    task automatic do_reset(input bit fs);
        reset = 1'b1;
        frame_start = fs;
        issue = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        frame_start = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
        bus.address = '0;
        bus.writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1. reset state and background everywhere
        check("rst_pix_rgb", {16'b0, pix_rgb}, 32'hFFFF);
        check("rst_pix_hit", {31'b0, pix_hit}, 32'h0);
        check("rst_pix_sel", {29'b0, pix_sel}, 32'h0);
        check("rst_spr_addr0", {22'b0, spr_addr[9:0]}, 32'h0);
        check("rst_commit_pend", {31'b0, commit_pend}, 32'h0);
        for (int k = 0; k < 20; k++) pix($urandom_range(0, 639), $urandom_range(0, 479));
        step(5, 5, 0, 0, 0, 0, 9'h0, 32'h0, 1);   // blanked pixel

        // 2. sprite 0 at (100,100), live only after frame_start
        place(0, 100, 100);
        wr(9'h10, 32'h1);
        wr(9'h11, 32'h1);
        pix(101, 102);            // not yet live
        frame();
        pix(101, 102);
        check("spr_addr0_65", {22'b0, spr_addr[9:0]}, 32'd65);
        pix(99, 102); pix(131, 131); pix(132, 131); pix(100, 100);
        drain();

        // unselected write and unmapped addresses are ignored
        step(0, 0, 0, 0, 0, 1, 9'h12, 32'h1234, 0);
        wr(9'h13, 32'hFFFF_FFFF);
        wr(9'h1FF, 32'h0);
        pix(10, 10);
        drain();
        wr(9'h12, 32'hFFFF_0841);  // bg, upper bits ignored
        drain();
        pix(10, 10); pix(101, 102);
        drain();

        // 3. overlapping sprites 0 and 1
        place(0, 200, 150);
        place(1, 200, 150);
        wr(9'h10, 32'h3);
        wr(9'h11, 32'h1);
        frame();
        for (int k = 0; k < 6; k++) pix(200 + $urandom_range(0, 31), 150 + $urandom_range(0, 31));
        drain();
        key_mode = 1'b1;
        for (int k = 0; k < 6; k++) pix(200 + $urandom_range(0, 31), 150 + $urandom_range(0, 31));
        drain();
        key_mode = 1'b0;

        // 4. right-edge clipping, no wrap
        place(2, 630, 10);
        wr(9'h10, 32'h4);
        wr(9'h11, 32'h1);
        frame();
        for (int px = 620; px < 640; px++) pix(px, 20);
        for (int px = 0; px < 22; px++) pix(px, 20);
        drain();

        // 5. x write and commit write in frame_start cycles
        place(0, 100, 100);
        wr(9'h10, 32'h1);
        wr(9'h11, 32'h1);
        step(0, 0, 0, 1, 1, 1, 9'h0, 32'd300, 0);   // live gets x=100, shadow=300
        pix(101, 102); pix(301, 102);
        step(0, 0, 0, 1, 1, 1, 9'h11, 32'h1, 0);    // commit_pend stays 1
        pix(101, 102); pix(301, 102);
        frame();
        pix(101, 102); pix(301, 102);
        drain();

        // random phase: pixels near sprites, interleaved writes and frames
        for (int c = 0; c < 400; c++) begin
            int k, px, py, sel;
            logic [8:0] a;
            bit fs, w;
            k  = $urandom_range(0, NUM - 1);
            px = (m_lx[k] > 639 ? $urandom_range(0, 639) : m_lx[k]) + $urandom_range(0, 40) - 4;
            py = (m_ly[k] > 479 ? $urandom_range(0, 479) : m_ly[k]) + $urandom_range(0, 40) - 4;
            if (px < 0) px = 0;
            if (px > 639) px = 639;
            if (py < 0) py = 0;
            if (py > 479) py = 479;
            fs = ($urandom_range(0, 9) == 0);
            w  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 9'($urandom_range(0, 2 * NUM - 1));
            else if (sel == 6) a = 9'h10;
            else if (sel == 7) a = 9'h11;
            else               a = 9'($urandom_range(12, 15));
            step(px, py, ($urandom_range(0, 9) != 0), fs, w, w, a,
                 (a < 9'(2 * NUM)) ? 32'($urandom_range(0, 660)) : $urandom, 1);
        end
        drain();

        // 6. reset mid-frame after writes, coinciding with frame_start
        place(3, 50, 60);
        wr(9'h10, 32'h8);
        wr(9'h11, 32'h1);
        frame();
        pix(51, 61); pix(52, 62);
        place(3, 400, 400);
        wr(9'h11, 32'h1);
        do_reset(1'b1);
        check("rst6_pix_hit", {31'b0, pix_hit}, 32'h0);
        check("rst6_pix_rgb", {16'b0, pix_rgb}, 32'hFFFF);
        check("rst6_commit_pend", {31'b0, commit_pend}, 32'h0);
        pix(51, 61); pix(401, 401);
        check("rst6_spr_addr", {22'b0, spr_addr[39:30]}, 32'h0);
        drain();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
